// File: rtl/ghist_queue_ctrl_if.sv
// Handshake and memory-port bundle for the global-history queue controller.
// The controller side uses the slave modport; the producer/consumer/memory side uses master.
interface ghist_queue_ctrl_if #(
    parameter int WIDTH = 72,
    parameter int AW    = 6
);
    logic             flush;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_data;
    logic [6:0]       count;
    logic [AW-1:0]    mem_R0_addr;
    logic             mem_R0_en;
    logic [WIDTH-1:0] mem_R0_data;
    logic [AW-1:0]    mem_W0_addr;
    logic             mem_W0_en;
    logic [WIDTH-1:0] mem_W0_data;

    modport slave (
        input  flush, enq_valid, enq_data, deq_ready, mem_R0_data,
        output enq_ready, deq_valid, deq_data, count,
               mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data
    );

    modport master (
        output flush, enq_valid, enq_data, deq_ready, mem_R0_data,
        input  enq_ready, deq_valid, deq_data, count,
               mem_R0_addr, mem_R0_en, mem_W0_addr, mem_W0_en, mem_W0_data
    );
endinterface

// File: rtl/ghist_queue_ctrl.sv
// Circular-queue controller for an external 1R1W sync-read ghist memory, with a
// read prefetch stage and a 2-entry flop output buffer feeding the dequeue port.
module ghist_queue_ctrl #(
    parameter int DEPTH = 40,
    parameter int WIDTH = 72,
    parameter int AW    = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    ghist_queue_ctrl_if.slave bus
);
    localparam logic [6:0]    DEPTH_C = 7'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [AW-1:0]    tail_q, head_q;
    logic [6:0]       mem_cnt_q;
    logic             rd_pend_q;
    logic [1:0]       ob_cnt_q;
    logic [WIDTH-1:0] obuf0_q, obuf1_q;

    logic       enq_ready, enq_fire, deq_valid, deq_fire, rd_en;
    logic [2:0] occ;

    always_comb begin
        enq_ready = !bus.flush && (mem_cnt_q < DEPTH_C);
        enq_fire  = bus.enq_valid && enq_ready;
        deq_valid = (ob_cnt_q != 2'd0);
        deq_fire  = deq_valid && bus.deq_ready;
        // Slots already spoken for in the output buffer after this cycle's pop.
        occ       = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, deq_fire};
        rd_en     = !bus.flush && (mem_cnt_q != 7'd0) && (occ < 3'd2);
    end

    assign bus.enq_ready   = enq_ready;
    assign bus.deq_valid   = deq_valid;
    assign bus.deq_data    = obuf0_q;
    assign bus.count       = mem_cnt_q + 7'(rd_pend_q) + 7'(ob_cnt_q);
    assign bus.mem_R0_addr = head_q;
    assign bus.mem_R0_en   = rd_en;
    assign bus.mem_W0_addr = tail_q;
    // enq_ready reads high during reset, so the write strobe is masked there explicitly.
    assign bus.mem_W0_en   = enq_fire && reset_n;
    assign bus.mem_W0_data = bus.enq_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tail_q    <= '0;
            head_q    <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= '0;
            obuf0_q   <= '0;
            obuf1_q   <= '0;
        end else if (bus.flush) begin
            tail_q    <= '0;
            head_q    <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= '0;
        end else begin
            if (enq_fire) tail_q <= (tail_q == LAST) ? '0 : tail_q + 1'b1;
            if (rd_en)    head_q <= (head_q == LAST) ? '0 : head_q + 1'b1;
            mem_cnt_q <= mem_cnt_q + 7'(enq_fire) - 7'(rd_en);
            rd_pend_q <= rd_en;

            case ({rd_pend_q, deq_fire})
                2'b11: begin
                    if (ob_cnt_q == 2'd1) begin
                        obuf0_q <= bus.mem_R0_data;
                    end else begin
                        obuf0_q <= obuf1_q;
                        obuf1_q <= bus.mem_R0_data;
                    end
                end
                2'b10: begin
                    if (ob_cnt_q == 2'd0) obuf0_q <= bus.mem_R0_data;
                    else                  obuf1_q <= bus.mem_R0_data;
                    ob_cnt_q <= ob_cnt_q + 2'd1;
                end
                2'b01: begin
                    obuf0_q  <= obuf1_q;
                    ob_cnt_q <= ob_cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ghist_queue_ctrl.sv
// Bench for ghist_queue_ctrl: queue-level reference model checked every cycle,
// a behavioural sync-read memory that returns poison when the read was not enabled.
module tb_ghist_queue_ctrl;
    localparam int DEPTH = 40;
    localparam int WIDTH = 72;
    localparam int AW    = 6;
    localparam logic [WIDTH-1:0] POISON = {WIDTH{1'b1}} ^ 72'h5A;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ghist_queue_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    ghist_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic [WIDTH-1:0] mem_arr [DEPTH];
    always @(posedge clock) begin
        if (bus.mem_W0_en) mem_arr[bus.mem_W0_addr] <= bus.mem_W0_data;
        if (bus.mem_R0_en) bus.mem_R0_data <= mem_arr[bus.mem_R0_addr];
        else               bus.mem_R0_data <= POISON;
    end

    int checks = 0;
    int errors = 0;

    // reference model: contents as queues, plus running pointers
    logic [WIDTH-1:0] m_mem[$];
    logic [WIDTH-1:0] m_ob[$];
    bit               m_inf_v;
    logic [WIDTH-1:0] m_inf_d;
    int               m_head, m_tail;

    // DUT observations from the most recent cycle
    bit               o_enq_ready, o_deq_valid, o_r0_en, o_w0_en, o_enq_fire, o_deq_fire;
    logic [WIDTH-1:0] o_deq_data;
    int               o_count, o_r0_addr, o_w0_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mem.delete();
        m_ob.delete();
        m_inf_v = 1'b0;
        m_inf_d = '0;
        m_head  = 0;
        m_tail  = 0;
    endtask

    task automatic cycle();
        bit e_er, e_dv, e_rd, dfire, efire;
        int occ;
        @(negedge clock);
        o_enq_ready = bus.enq_ready;
        o_deq_valid = bus.deq_valid;
        o_deq_data  = bus.deq_data;
        o_count     = int'(bus.count);
        o_r0_en     = bus.mem_R0_en;
        o_r0_addr   = int'(bus.mem_R0_addr);
        o_w0_en     = bus.mem_W0_en;
        o_w0_addr   = int'(bus.mem_W0_addr);
        o_enq_fire  = bus.enq_valid && bus.enq_ready;
        o_deq_fire  = bus.deq_valid && bus.deq_ready;

        e_er  = !bus.flush && (m_mem.size() < DEPTH);
        e_dv  = (m_ob.size() > 0);
        dfire = e_dv && bus.deq_ready;
        efire = bus.enq_valid && e_er;
        occ   = m_ob.size() + int'(m_inf_v) - int'(dfire);
        e_rd  = !bus.flush && (m_mem.size() > 0) && (occ < 2);

        chk("enq_ready", int'(o_enq_ready), int'(e_er));
        chk("deq_valid", int'(o_deq_valid), int'(e_dv));
        if (e_dv) chk_d("deq_data", o_deq_data, m_ob[0]);
        chk("count", o_count, m_mem.size() + int'(m_inf_v) + m_ob.size());
        chk("mem_R0_en", int'(o_r0_en), int'(e_rd));
        if (e_rd) chk("mem_R0_addr", o_r0_addr, m_head);
        chk("mem_W0_en", int'(o_w0_en), int'(efire));
        if (efire) begin
            chk("mem_W0_addr", o_w0_addr, m_tail);
            chk_d("mem_W0_data", bus.mem_W0_data, bus.enq_data);
        end

        if (bus.flush) begin
            model_reset();
        end else begin
            if (dfire) void'(m_ob.pop_front());
            if (m_inf_v) m_ob.push_back(m_inf_d);
            m_inf_v = e_rd;
            if (e_rd) begin
                m_inf_d = m_mem.pop_front();
                m_head  = (m_head + 1) % DEPTH;
            end
            if (efire) begin
                m_mem.push_back(bus.enq_data);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int acc, nd, bubbles;
        bit started, got;
        int waddr[4];

        bus.flush     = 1'b0;
        bus.enq_valid = 1'b1;
        bus.enq_data  = '0;
        bus.deq_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        chk("rst_enq_ready", int'(bus.enq_ready), 1);
        chk("rst_deq_valid", int'(bus.deq_valid), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_r0_en", int'(bus.mem_R0_en), 0);
        chk("rst_w0_en", int'(bus.mem_W0_en), 0);
        bus.enq_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // single entry latency
        bus.deq_ready = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 72'hA5;
        cycle();
        chk("t1_c0_w0_en", int'(o_w0_en), 1);
        chk("t1_c0_w0_addr", o_w0_addr, 0);
        bus.enq_valid = 1'b0;
        cycle();
        chk("t1_c1_r0_en", int'(o_r0_en), 1);
        chk("t1_c1_r0_addr", o_r0_addr, 0);
        chk("t1_c1_deq_valid", int'(o_deq_valid), 0);
        cycle();
        chk("t1_c2_deq_valid", int'(o_deq_valid), 0);
        chk("t1_c2_count", o_count, 1);
        cycle();
        chk("t1_c3_deq_valid", int'(o_deq_valid), 1);
        chk_d("t1_c3_deq_data", o_deq_data, 72'hA5);
        cycle();
        chk("t1_c4_deq_valid", int'(o_deq_valid), 0);
        chk("t1_c4_count", o_count, 0);

        // fill to capacity under backpressure, then drain
        bus.deq_ready = 1'b0;
        bus.enq_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 60; i++) begin
            bus.enq_data = 72'(acc);
            cycle();
            if (o_enq_fire) acc++;
        end
        bus.enq_valid = 1'b0;
        cycle();
        chk("t2_accepted", acc, DEPTH + 2);
        chk("t2_count", o_count, 42);
        chk("t2_enq_ready", int'(o_enq_ready), 0);
        bus.deq_ready = 1'b1;
        nd = 0; bubbles = 0; started = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (o_deq_fire) begin
                chk_d("t2_order", o_deq_data, 72'(nd));
                nd++;
                started = 1'b1;
            end else if (started && nd < 42) begin
                bubbles++;
            end
        end
        chk("t2_drained", nd, 42);
        chk("t2_bubbles", bubbles, 0);

        // streaming with wrap
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        acc = 0; nd = 0; bubbles = 0; started = 1'b0;
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 260 && nd < 200; i++) begin
            bus.enq_valid = (acc < 200);
            bus.enq_data  = 72'(acc);
            cycle();
            if (o_enq_fire) begin
                if (acc >= 38 && acc <= 41) waddr[acc-38] = o_w0_addr;
                acc++;
            end
            if (o_deq_fire) begin
                chk_d("t3_order", o_deq_data, 72'(nd));
                nd++;
                started = 1'b1;
            end else if (started && nd < 200) begin
                bubbles++;
            end
        end
        bus.enq_valid = 1'b0;
        chk("t3_drained", nd, 200);
        chk("t3_bubbles", bubbles, 0);
        chk("t3_waddr38", waddr[0], 38);
        chk("t3_waddr39", waddr[1], 39);
        chk("t3_waddr40", waddr[2], 0);
        chk("t3_waddr41", waddr[3], 1);

        // random traffic with backpressure
        for (int i = 0; i < 10000; i++) begin
            bus.enq_valid = 1'($urandom_range(0, 1));
            bus.deq_ready = 1'($urandom_range(0, 1));
            bus.enq_data  = {8'($urandom), $urandom, $urandom};
            cycle();
        end

        // flush with a read in flight
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 50; i++) cycle();
        bus.deq_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && acc < 10; i++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = 72'(100 + acc);
            cycle();
            if (o_enq_fire) acc++;
        end
        bus.enq_valid = 1'b0;
        repeat (5) cycle();
        bus.deq_ready = 1'b1;
        cycle();
        chk("t5_pop_issues_read", int'(o_r0_en), 1);
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 72'h55;
        cycle();
        chk("t5_flush_enq_ready", int'(o_enq_ready), 0);
        chk("t5_flush_w0_en", int'(o_w0_en), 0);
        chk("t5_flush_r0_en", int'(o_r0_en), 0);
        bus.flush     = 1'b0;
        bus.enq_valid = 1'b0;
        cycle();
        chk("t5_post_deq_valid", int'(o_deq_valid), 0);
        chk("t5_post_count", o_count, 0);
        bus.enq_valid = 1'b1;
        bus.enq_data  = 72'h77;
        cycle();
        bus.enq_valid = 1'b0;
        bus.deq_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            if (o_deq_fire) begin
                got = 1'b1;
                chk_d("t5_deq_data", o_deq_data, 72'h77);
            end
        end
        chk("t5_deq_seen", int'(got), 1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) begin
            bus.enq_valid = 1'b1;
            bus.enq_data  = 72'(500 + i);
            cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_deq_valid", int'(bus.deq_valid), 0);
        chk("t6_r0_en", int'(bus.mem_R0_en), 0);
        chk("t6_w0_en", int'(bus.mem_W0_en), 0);
        chk("t6_count", int'(bus.count), 0);
        model_reset();
        bus.enq_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_data  = 72'h99;
        cycle();
        chk("t6_first_w0_en", int'(o_w0_en), 1);
        chk("t6_first_w0_addr", o_w0_addr, 0);
        bus.enq_valid = 1'b0;
        repeat (6) cycle();
        chk("t6_drained_count", o_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ghist_queue_ctrl.md
# ghist_queue_ctrl

Circular-queue controller that owns both ports of an external 1R1W synchronous-read global-history memory (DEPTH x WIDTH, one-cycle registered-address read, read data undefined unless the read was enabled the previous cycle). It accepts history snapshots on a valid/ready enqueue port, writes them into the memory, prefetches them back in order, and presents them on a flop-sourced valid/ready dequeue port. It sits in the fetch-target-queue next to the ghist memory and is the reading/control end of that memory's interface.

## Interface

- DEPTH, 40, memory entries; any value 2..64 (not required to be a power of two)
- WIDTH, 72, history entry width in bits
- AW, 6, memory address width; ceil(log2(DEPTH))

- clock  in  1  sole clock; also drives the memory's R0_clk/W0_clk
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear
- enq_valid  in  1  enqueue request
- enq_ready  out  1  enqueue accepted when high with enq_valid
- enq_data  in  WIDTH  history entry
- deq_valid  out  1  head entry available
- deq_ready  in  1  consumer accepts head
- deq_data  out  WIDTH  head entry, driven from flops
- count  out  7  total entries held (memory + in-flight + output buffer), max DEPTH+2
- mem_R0_addr  out  AW  read address (head pointer)
- mem_R0_en  out  1  read enable
- mem_R0_data  in  WIDTH  read data, valid one cycle after mem_R0_en
- mem_W0_addr  out  AW  write address (tail pointer)
- mem_W0_en  out  1  write enable
- mem_W0_data  out  WIDTH  write data (= enq_data)

## Operation

- State: tail, head (AW bits, 0..DEPTH-1), mem_cnt (entries written, not yet read), rd_pend (read issued last cycle), 2-entry output FIFO obuf[0..1] with ob_cnt (0..2).
- Enqueue: enq_ready = !flush && mem_cnt < DEPTH. On fire: mem_W0_en=1, mem_W0_addr=tail, mem_W0_data=enq_data; tail increments, DEPTH-1 wraps to 0.
- Read issue: mem_R0_en = !flush && mem_cnt > 0 && (ob_cnt + rd_pend - deq_fire) < 2; mem_R0_addr=head; on issue head increments with same wrap, mem_cnt decrements. mem_cnt updates net of simultaneous enq and read (+1-1 = unchanged).
- Capture: when rd_pend, mem_R0_data is pushed into obuf at the end of that cycle. mem_R0_data is never sampled when rd_pend=0.
- Dequeue: deq_valid = ob_cnt > 0; deq_data = obuf[0]; on deq_fire obuf shifts. Simultaneous push and pop keep ob_cnt constant with order preserved.
- Read/write collision impossible: a read requires mem_cnt>0 and a write requires mem_cnt<DEPTH, so head==tail never occurs with both enabled.
- count = mem_cnt + rd_pend + ob_cnt.
- flush: next cycle head=tail=0, mem_cnt=0, ob_cnt=0, rd_pend=0. The returning data of any in-flight read is discarded. enq_ready=0 and mem_R0_en=0 during the flush cycle. deq_valid is unaffected in the flush cycle; a deq_fire in that cycle is legal and consumes the entry.
- Reset (reset_n low, any time, asynchronous): all state is 0. Outputs while in reset: enq_ready=1, deq_valid=0, mem_R0_en=0, mem_W0_en=0, count=0. Reset mid-operation drops all contents. Memory contents are not cleared.

## Timing

- Enqueue-to-dequeue latency when empty: enq fire in cycle t -> read issued t+1 -> data captured end of t+2 -> deq_valid high in t+3.
- Sustained throughput is 1 entry/cycle in each direction with deq_ready held high. Steady state is ob_cnt=1, rd_pend=1.
- Capacity is DEPTH+2 (42 by default). enq_ready falls only when mem_cnt reaches DEPTH.
- All outputs except enq_ready, mem_R0_en, mem_W0_* (combinational from flops and inputs) come directly from flops.

## Test plan

- Reset, then a single enq of 0xA5 (zero-extended) in cycle 0 with deq_ready=1 -> mem_R0_en in cycle 1 at addr 0; deq_valid=1 with deq_data=0xA5 in cycle 3 only; count back to 0 in cycle 4.
- deq_ready=0 while enq_valid is held with data i=0,1,2,... -> exactly 42 accepted; enq_ready=0 after; count=42. Release deq_ready -> 0..41 dequeue in order, one per cycle.
- Continuous enq/deq for 200 entries, data = index -> no bubbles after the first deq; order is preserved across the head/tail wrap 39->0; mem_W0_addr sequence 38,39,0,1.
- Random deq_ready backpressure at 50% with random enq_valid, 10k cycles -> scoreboard matches, count equals the model, and mem_R0_data is never captured without rd_pend.
- Fill with 10 entries, assert flush in a cycle with rd_pend=1 and enq_valid=1 -> enq not accepted; next cycle deq_valid=0, count=0; the next enq of 0x77 dequeues as 0x77 (the stale in-flight word is discarded).
- Assert reset_n low asynchronously mid-stream (no clock edge) -> deq_valid, mem_R0_en, and mem_W0_en go low immediately and count=0. After release, the first enq is written to addr 0.
